if_id_skid: RTL and testbench

Parametrised IF/ID pipeline register with a valid/ready handshake, a two-entry skid buffer, and separate hold (stall) and discard (flush) controls. It sits between the fetch stage and the decode stage of the GeMIPS pipeline. It fully registers the fetch-to-decode boundary. `in_ready` depends only on internal state, so there is no combinational path from the decode-side `out_ready` back to fetch.

---
 rtl/if_id_skid.sv | 122 ++++++++++++
 tb/tb_if_id_skid.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : if_id_skid                                                    |
// | Description : IF/ID pipeline register with a two-entry skid buffer, hold    |
// |               (stall) and discard (flush); if_ready decodes state only.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module if_id_skid #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                EXC_W    = 5,
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic [EXC_W-1:0]  if_exc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [EXC_W-1:0]  id_exc,
  input  logic              stall,
  input  logic              flush
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_m_pc;
  logic [INST_W-1:0]   r_m_inst;
  logic [EXC_W-1:0]    r_m_exc;
  logic [ADDR_W-1:0]   r_s_pc;
  logic [INST_W-1:0]   r_s_inst;
  logic [EXC_W-1:0]    r_s_exc;
  logic                w_acc;
  logic                w_take;
  logic                w_load_m_in;
  logic                w_load_m_s;
  logic                w_load_s_in;

  assign if_ready = (r_state != ST_TWO);
  assign id_valid = (r_state != ST_EMPTY);
  assign w_acc    = if_valid & if_ready;
  assign w_take   = id_valid & id_ready & ~stall;

  always_comb begin
    w_state_nxt = r_state;
    w_load_m_in = 1'b0;
    w_load_m_s  = 1'b0;
    w_load_s_in = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_nxt = ST_ONE;
            w_load_m_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_take) begin
            w_load_m_in = 1'b1;
          end else if (w_acc) begin
            w_state_nxt = ST_TWO;
            w_load_s_in = 1'b1;
          end else if (w_take) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_take) begin
            w_state_nxt = ST_ONE;
            w_load_m_s  = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload registers need no reset: outputs are masked while state is EMPTY.
  always_ff @(posedge clk) begin
    if (w_load_m_in) begin
      r_m_pc   <= if_pc;
      r_m_inst <= if_inst;
      r_m_exc  <= if_exc;
    end else if (w_load_m_s) begin
      r_m_pc   <= r_s_pc;
      r_m_inst <= r_s_inst;
      r_m_exc  <= r_s_exc;
    end
    if (w_load_s_in) begin
      r_s_pc   <= if_pc;
      r_s_inst <= if_inst;
      r_s_exc  <= if_exc;
    end
  end

  assign id_pc   = id_valid ? r_m_pc   : {ADDR_W{1'b0}};
  assign id_inst = id_valid ? r_m_inst : NOP_INST;
  assign id_exc  = id_valid ? r_m_exc  : {EXC_W{1'b0}};

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_if_id_skid                                                 |
// | Description : Directed and random checks of if_id_skid against a queue     |
// |               model of the fetch-to-decode buffer.                          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_if_id_skid;

  localparam logic [31:0] C_NOP = 32'hDEAD_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [4:0]  if_exc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [4:0]  id_exc;
  logic        stall;
  logic        flush;

  if_id_skid #(
    .ADDR_W   (32),
    .INST_W   (32),
    .EXC_W    (5),
    .NOP_INST (C_NOP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_exc   (if_exc),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_exc   (id_exc),
    .stall    (stall),
    .flush    (flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  exc;
  } ent_t;

  // Model: an ordered buffer holding at most two accepted entries.
  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  exc;
    v    = (q.size() != 0);
    pc   = v ? q[0].pc   : 32'h0;
    inst = v ? q[0].inst : C_NOP;
    exc  = v ? q[0].exc  : 5'h0;
    chk("if_ready", {31'b0, if_ready}, {31'b0, (q.size() < 2)});
    chk("id_valid", {31'b0, id_valid}, {31'b0, v});
    chk("id_pc",    id_pc,             pc);
    chk("id_inst",  id_inst,           inst);
    chk("id_exc",   {27'b0, id_exc},   {27'b0, exc});
  endtask

  task automatic tick();
    logic acc;
    logic take;
    ent_t e;
    acc  = if_valid && (q.size() < 2);
    take = (q.size() != 0) && id_ready && !stall;
    e    = '{pc: if_pc, inst: if_inst, exc: if_exc};
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (take) void'(q.pop_front());
      if (acc)  q.push_back(e);
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] exc,
                       input logic rdy, input logic stl, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_inst  = pc ^ 32'h5A5A_0000;
    if_exc   = exc;
    id_ready = rdy;
    stall    = stl;
    flush    = fl;
    tick();
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'h1234; if_exc = 5'h0;
    id_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Streaming
    drive(1, 32'h0, 0, 1, 0, 0);
    drive(1, 32'h4, 0, 1, 0, 0);
    drive(1, 32'h8, 0, 1, 0, 0);
    drive(1, 32'hC, 0, 1, 0, 0);
    drive(0, 32'h0, 0, 1, 0, 0);

    // Backpressure, then release with fetch re-offering 0x18
    drive(1, 32'h10, 0, 0, 0, 0);
    drive(1, 32'h14, 0, 0, 0, 0);
    drive(1, 32'h18, 0, 0, 0, 0);
    drive(1, 32'h18, 0, 1, 0, 0);
    drive(1, 32'h18, 0, 1, 0, 0);
    drive(0, 32'h0,  0, 1, 0, 0);
    drive(0, 32'h0,  0, 1, 0, 0);

    // Stall in TWO, then stall together with flush
    drive(1, 32'h10, 0, 0, 0, 0);
    drive(1, 32'h14, 0, 0, 0, 0);
    drive(0, 32'h0,  0, 1, 1, 0);
    drive(0, 32'h0,  0, 1, 1, 0);
    drive(0, 32'h0,  0, 1, 1, 0);
    drive(0, 32'h0,  0, 1, 1, 1);
    drive(0, 32'h0,  0, 1, 0, 0);

    // Flush with input in ONE, then refill
    drive(1, 32'h3C, 0, 0, 0, 0);
    drive(1, 32'h40, 0, 0, 0, 1);
    drive(1, 32'h44, 0, 1, 0, 0);
    drive(0, 32'h0,  0, 1, 0, 0);

    // Exception field and the following bubble
    drive(1, 32'h80, 5'h04, 1, 0, 0);
    drive(0, 32'h0,  5'h1F, 1, 0, 0);
    drive(0, 32'h0,  0,     1, 0, 0);

    // Mid-operation reset with input offered
    drive(1, 32'h90, 0, 0, 0, 0);
    drive(1, 32'h94, 0, 0, 0, 0);
    rst = 1'b1;
    drive(1, 32'h98, 0, 1, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc    = $urandom;
      if_inst  = $urandom;
      if_exc   = 5'($urandom_range(0, 31));
      id_ready = ($urandom_range(0, 2) != 0);
      stall    = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
